// File: rtl/vliw_uart_fifo.sv
// vliw_uart_fifo
//   Buffering bridge between the VLIW core and vliw_uart, on one clock domain.
//   TX path: the core pushes bytes into a show-ahead TX FIFO. A small
//   sequencer drains that FIFO into the UART with the start/busy handshake.
//   RX path: bytes flagged by the UART's has_byte are collected into a
//   show-ahead RX FIFO, which the core pops. Each collected byte is
//   acknowledged with a one-cycle clr_hb pulse.
//
// Ports
//   clk, rst_n             system clock (rising edge), async active-low reset
//   tx_data, tx_wr         core push into the TX FIFO
//   tx_full, tx_level      TX FIFO status
//   rx_data, rx_rd         RX FIFO head (combinational) and pop
//   rx_empty, rx_level     RX FIFO status
//   tx_overflow            sticky: push attempted while TX FIFO full
//   rx_overrun             sticky: UART byte dropped, RX FIFO full
//   clr_err                clears both sticky flags (a same-cycle set wins)
//   uart_din, uart_start   to the UART transmitter (start is a 1-cycle pulse)
//   uart_busy              from the UART transmitter
//   uart_dout, uart_has_byte, uart_clr_hb   UART receiver handshake
//
// DEPTH_LOG2 sets each FIFO's depth to 2**DEPTH_LOG2; supported range 1..6.
module vliw_uart_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            tx_data,
  input  logic                  tx_wr,
  output logic                  tx_full,
  output logic [DEPTH_LOG2:0]   tx_level,
  output logic [7:0]            rx_data,
  input  logic                  rx_rd,
  output logic                  rx_empty,
  output logic [DEPTH_LOG2:0]   rx_level,
  output logic                  tx_overflow,
  output logic                  rx_overrun,
  input  logic                  clr_err,
  output logic [7:0]            uart_din,
  output logic                  uart_start,
  input  logic                  uart_busy,
  input  logic [7:0]            uart_dout,
  input  logic                  uart_has_byte,
  output logic                  uart_clr_hb
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = {DEPTH_LOG2{1'b0}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(32'd1);
  localparam logic [DEPTH_LOG2:0]   LVL_ZERO = {(DEPTH_LOG2 + 1){1'b0}};
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(32'd1);
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = LVL_ONE << DEPTH_LOG2;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_START     = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_WAIT_DONE = 2'd3
  } tx_state_t;

  // Occupancy after one cycle; push+pop together leaves it unchanged.
  function automatic logic [DEPTH_LOG2:0] next_level(input logic [DEPTH_LOG2:0] lvl,
                                                     input logic push,
                                                     input logic pop);
    logic [DEPTH_LOG2:0] res;
    case ({push, pop})
      2'b10:   res = lvl + LVL_ONE;
      2'b01:   res = lvl - LVL_ONE;
      default: res = lvl;
    endcase
    return res;
  endfunction

  // ---------------- TX FIFO ----------------
  logic [7:0]            tx_mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wr_ptr_r;
  logic [DEPTH_LOG2-1:0] tx_rd_ptr_r;
  logic [DEPTH_LOG2:0]   tx_level_r;
  logic                  tx_full_s;
  logic                  tx_empty_s;
  logic                  tx_push_s;
  logic                  tx_pop_s;
  logic                  tx_ovf_set_s;

  assign tx_full_s  = (tx_level_r == LVL_FULL);
  assign tx_empty_s = (tx_level_r == LVL_ZERO);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is taken.
  assign tx_push_s    = tx_wr && (!tx_full_s || tx_pop_s);
  assign tx_ovf_set_s = tx_wr && tx_full_s && !tx_pop_s;

  // TX storage write (no reset needed: entries are only read while valid)
  always_ff @(posedge clk) begin
    if (tx_push_s) begin
      tx_mem_r[tx_wr_ptr_r] <= tx_data;
    end
  end

  // TX pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr_r <= PTR_ZERO;
      tx_rd_ptr_r <= PTR_ZERO;
      tx_level_r  <= LVL_ZERO;
    end else begin
      if (tx_push_s) begin
        tx_wr_ptr_r <= tx_wr_ptr_r + PTR_ONE;
      end
      if (tx_pop_s) begin
        tx_rd_ptr_r <= tx_rd_ptr_r + PTR_ONE;
      end
      tx_level_r <= next_level(tx_level_r, tx_push_s, tx_pop_s);
    end
  end

  // ---------------- TX sequencer ----------------
  tx_state_t  tx_state_r;
  tx_state_t  tx_state_n_s;
  logic       uart_start_r;
  logic       uart_start_n_s;
  logic [7:0] uart_din_r;
  logic [7:0] uart_din_n_s;

  // TX sequencer state and registered UART outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_r   <= TX_IDLE;
      uart_start_r <= 1'b0;
      uart_din_r   <= 8'h00;
    end else begin
      tx_state_r   <= tx_state_n_s;
      uart_start_r <= uart_start_n_s;
      uart_din_r   <= uart_din_n_s;
    end
  end

  // TX sequencer next state; the pop happens as the head is loaded into uart_din
  always_comb begin
    tx_state_n_s   = tx_state_r;
    uart_start_n_s = 1'b0;
    uart_din_n_s   = uart_din_r;
    tx_pop_s       = 1'b0;
    case (tx_state_r)
      TX_IDLE: begin
        if (!tx_empty_s) begin
          uart_din_n_s   = tx_mem_r[tx_rd_ptr_r];
          uart_start_n_s = 1'b1;
          tx_pop_s       = 1'b1;
          tx_state_n_s   = TX_START;
        end else begin
          tx_state_n_s = TX_IDLE;
        end
      end
      TX_START: begin
        tx_state_n_s = TX_WAIT_BUSY;
      end
      TX_WAIT_BUSY: begin
        // busy only rises two cycles after start, so wait for it explicitly
        if (uart_busy) begin
          tx_state_n_s = TX_WAIT_DONE;
        end else begin
          tx_state_n_s = TX_WAIT_BUSY;
        end
      end
      TX_WAIT_DONE: begin
        if (!uart_busy) begin
          tx_state_n_s = TX_IDLE;
        end else begin
          tx_state_n_s = TX_WAIT_DONE;
        end
      end
      default: begin
        tx_state_n_s = TX_IDLE;
      end
    endcase
  end

  // ---------------- RX FIFO and collector ----------------
  logic [7:0]            rx_mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rx_rd_ptr_r;
  logic [DEPTH_LOG2:0]   rx_level_r;
  logic [1:0]            rx_holdoff_r;
  logic                  uart_clr_hb_r;
  logic                  rx_full_s;
  logic                  rx_empty_s;
  logic                  rx_sample_s;
  logic                  rx_push_s;
  logic                  rx_pop_s;
  logic                  rx_drop_s;

  assign rx_full_s   = (rx_level_r == LVL_FULL);
  assign rx_empty_s  = (rx_level_r == LVL_ZERO);
  // has_byte stays high until the UART sees clr_hb; the holdoff masks that stale level.
  assign rx_sample_s = uart_has_byte && (rx_holdoff_r == 2'd0);
  assign rx_pop_s    = rx_rd && !rx_empty_s;
  assign rx_push_s   = rx_sample_s && (!rx_full_s || rx_pop_s);
  assign rx_drop_s   = rx_sample_s && rx_full_s && !rx_pop_s;

  // RX storage write
  always_ff @(posedge clk) begin
    if (rx_push_s) begin
      rx_mem_r[rx_wr_ptr_r] <= uart_dout;
    end
  end

  // RX pointers, occupancy, holdoff and clr_hb pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_ptr_r   <= PTR_ZERO;
      rx_rd_ptr_r   <= PTR_ZERO;
      rx_level_r    <= LVL_ZERO;
      rx_holdoff_r  <= 2'd0;
      uart_clr_hb_r <= 1'b0;
    end else begin
      if (rx_push_s) begin
        rx_wr_ptr_r <= rx_wr_ptr_r + PTR_ONE;
      end
      if (rx_pop_s) begin
        rx_rd_ptr_r <= rx_rd_ptr_r + PTR_ONE;
      end
      rx_level_r <= next_level(rx_level_r, rx_push_s, rx_pop_s);
      if (rx_sample_s) begin
        rx_holdoff_r <= 2'd2;
      end else if (rx_holdoff_r != 2'd0) begin
        rx_holdoff_r <= rx_holdoff_r - 2'd1;
      end
      // Acknowledge every sampled byte, whether stored or dropped
      uart_clr_hb_r <= rx_sample_s;
    end
  end

  // ---------------- Sticky error flags ----------------
  logic tx_overflow_r;
  logic rx_overrun_r;

  // Sticky flags; a set condition outranks clr_err in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_overflow_r <= 1'b0;
      rx_overrun_r  <= 1'b0;
    end else begin
      tx_overflow_r <= tx_ovf_set_s || (tx_overflow_r && !clr_err);
      rx_overrun_r  <= rx_drop_s || (rx_overrun_r && !clr_err);
    end
  end

  // ---------------- Outputs ----------------
  assign tx_full     = tx_full_s;
  assign tx_level    = tx_level_r;
  assign rx_empty    = rx_empty_s;
  assign rx_level    = rx_level_r;
  // Head is forced to zero when empty so reset and idle values are deterministic
  assign rx_data     = rx_empty_s ? 8'h00 : rx_mem_r[rx_rd_ptr_r];
  assign tx_overflow = tx_overflow_r;
  assign rx_overrun  = rx_overrun_r;
  assign uart_din    = uart_din_r;
  assign uart_start  = uart_start_r;
  assign uart_clr_hb = uart_clr_hb_r;

endmodule
